// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int NUM_BITS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                borrow_in;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] diff;
  logic                underflow;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, underflow
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, underflow
  );

endinterface

// File: rtl/serial_subtractor_adder_1bit.sv
// Single-bit full adder used as the per-cycle datapath of the serial subtractor.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock, with valid/ready on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  sub_state_t          state_q, state_d;
  logic [NUM_BITS-1:0] a_sr_q, a_sr_d;
  logic [NUM_BITS-1:0] b_sr_q, b_sr_d;
  logic [NUM_BITS-1:0] res_q, res_d;
  logic [NUM_BITS-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                uf_q, uf_d;
  logic                bit_sum, bit_carry;
  logic [NUM_BITS-1:0] res_shifted;

  // Subtraction as a + ~b + ~borrow_in; the final carry is the inverted borrow.
  adder_1bit u_adder (
    .a         (a_sr_q[0]),
    .b         (b_sr_q[0]),
    .carry_in  (carry_q),
    .sum       (bit_sum),
    .carry_out (bit_carry)
  );

  assign res_shifted = {bit_sum, res_q[NUM_BITS-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    uf_d    = uf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = ~bus.b;
          carry_d = ~bus.borrow_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = res_shifted;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = bit_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_shifted;
          uf_d    = ~bit_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.underflow = uf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit vectors plus exhaustive 4-bit sweep.
module tb_serial_subtractor;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.NUM_BITS(8)) bus8 ();
  serial_subtractor_if #(.NUM_BITS(4)) bus4 ();

  serial_subtractor #(.NUM_BITS(8)) u_dut8 (.clk(clk), .n_rst(n_rst), .bus(bus8));
  serial_subtractor #(.NUM_BITS(4)) u_dut4 (.clk(clk), .n_rst(n_rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic bin, input logic [7:0] ed, input logic eu);
    @(negedge clk);
    bus8.a         = av;
    bus8.b         = bv;
    bus8.borrow_in = bin;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus8.in_ready), 32'd0);
    repeat (7) @(posedge clk);
    #1 check({tag, "_early"}, 32'(bus8.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, 32'(bus8.out_valid), 32'd1);
    check({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
    check({tag, "_uf"}, 32'(bus8.underflow), 32'(eu));
    @(posedge clk);
    #1;
    check({tag, "_rdy"}, 32'(bus8.in_ready), 32'd1);
    check({tag, "_vld_low"}, 32'(bus8.out_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst    = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.borrow_in = 1'b0; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.borrow_in = 1'b0; bus4.out_ready = 1'b1;

    // Asynchronous reset asserted between clock edges
    #12 n_rst = 1'b0;
    #1;
    check("rst_vld", 32'(bus8.out_valid), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'd0);
    check("rst_uf", 32'(bus8.underflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("rst_rdy", 32'(bus8.in_ready), 32'd1);
    check("rst_rdy4", 32'(bus4.in_ready), 32'd1);

    run8("t100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
    run8("t0_1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8("t80_7f_b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    run8("t0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);

    // Backpressure with ignored in_valid pulses
    @(negedge clk);
    bus8.a = 8'd200; bus8.b = 8'd55; bus8.borrow_in = 1'b0;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("bp_vld0", 32'(bus8.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.in_valid = i[0];
      bus8.a = 8'd1; bus8.b = 8'd2;
      @(posedge clk);
      #1;
      check("bp_diff", 32'(bus8.diff), 32'd145);
      check("bp_vld", 32'(bus8.out_valid), 32'd1);
      check("bp_rdy", 32'(bus8.in_ready), 32'd0);
    end
    // Release together with a pending in_valid: only returns to IDLE
    @(negedge clk);
    bus8.a = 8'd50; bus8.b = 8'd20; bus8.borrow_in = 1'b0;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rdy", 32'(bus8.in_ready), 32'd1);
    check("rel_hold", 32'(bus8.diff), 32'd145);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    check("rel_acc", 32'(bus8.in_ready), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rel_vld", 32'(bus8.out_valid), 32'd1);
    check("rel_diff", 32'(bus8.diff), 32'd30);
    @(posedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    bus8.a = 8'd77; bus8.b = 8'd5; bus8.borrow_in = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_vld", 32'(bus8.out_valid), 32'd0);
    check("mid_rdy", 32'(bus8.in_ready), 32'd1);
    check("mid_diff", 32'(bus8.diff), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    run8("t9_3", 8'd9, 8'd3, 1'b0, 8'd6, 1'b0);

    // Exhaustive 4-bit sweep against a plain arithmetic reference
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          logic [4:0] ref5;
          ref5 = 5'(av) - 5'(bv) - 5'(bi);
          @(negedge clk);
          bus4.a = 4'(av); bus4.b = 4'(bv); bus4.borrow_in = bi[0];
          bus4.in_valid = 1'b1;
          @(posedge clk);
          #1 bus4.in_valid = 1'b0;
          repeat (4) @(posedge clk);
          #1;
          check("ex_vld", 32'(bus4.out_valid), 32'd1);
          check("ex_diff", 32'(bus4.diff), 32'(ref5[3:0]));
          check("ex_uf", 32'(bus4.underflow), 32'(ref5[4]));
          @(posedge clk);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
